nor10_interval_timer: RTL and testbench
=======================================

Name: nor10_interval_timer

Overview:
- Programmable 10-bit down-counting interval timer that produces the 10-bit count vector consumed by the schematic NOR10 zero-detect macro.
- Also provides its own registered terminal-count pulse, so schematic users can take either the raw vector (for NOR10) or the ready-made TC.
- Used as the tick or timeout source in schematic-capture designs.

Parameters:
- WIDTH, 10, count/period width; the NOR10 consumer fixes this at 10, other values are for reuse only.
- AUTO_RELOAD, 0, 1 = reload PERIOD and keep running after TC; 0 = one-shot, return to IDLE.
- PRESCALE, 3, prescaler divide-minus-one; used only when TIMER_PRESCALE_EN is defined.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RSTN  input  1  synchronous, active-low reset.
- LOAD  input  1  strobe; captures LDVAL into the period register.
- LDVAL  input  WIDTH  period value.
- START  input  1  strobe; begin (or restart) counting from the period register.
- STOP  input  1  strobe; abort the count and return to IDLE.
- CE  input  1  count enable; decrement qualifier.
- CNT  output  WIDTH  current count register; drives the NOR10 inputs A0..A9.
- ZERO  output  1  combinational ~|CNT, identical to the NOR10 result.
- TC  output  1  registered one-cycle terminal-count pulse.
- BUSY  output  1  high in RUN.

Behaviour:
- Reset (RSTN=0 at an edge), regardless of state: period register=0, CNT=0, TC=0, BUSY=0, state=IDLE. ZERO therefore reads 1.
- States: IDLE, RUN.
- LOAD, any state: period register <= LDVAL next edge.
  - In RUN, CNT is not disturbed; the new value takes effect at the next START or auto-reload.
  - LOAD and START in the same cycle: START uses the old period value (registered-load semantics).
- IDLE:
  - START=1 and STOP=0 -> next edge CNT<=period, state=RUN, BUSY=1.
  - Otherwise CNT holds.
- RUN, priority highest first:
  - STOP=1 -> IDLE, BUSY=0, CNT holds its value, no TC. STOP beats a simultaneous START.
  - START=1 -> CNT<=period (restart), stay in RUN, no TC even if CNT==0.
  - CE=1 and CNT!=0 -> CNT<=CNT-1.
  - CE=1 and CNT==0 -> TC=1 for exactly the next cycle.
    - AUTO_RELOAD=1: CNT<=period, stay in RUN.
    - AUTO_RELOAD=0: state=IDLE, BUSY=0, CNT stays 0.
  - CE=0 -> hold.
- Timing: with CE held high, TC asserts P+1 cycles after the cycle BUSY first asserts (P = period). P=0 gives TC one cycle after BUSY rises. Auto-reload repeat interval is P+1 cycles.
- TC is never asserted for two consecutive cycles, except with AUTO_RELOAD and P=0, where TC stays high continuously.
- Arithmetic is unsigned. The decrement never wraps, because the zero case is intercepted.
- ZERO is purely combinational from CNT, with no added latency.

Optional Feature:
- Macro: TIMER_PRESCALE_EN.
- Defined:
  - A prescaler counter, width clog2(PRESCALE+1), counts CE cycles.
  - CNT decrements or expires only on the CE cycle where the prescaler equals PRESCALE; the prescaler then wraps to 0.
  - The prescaler clears on reset, on START and on STOP.
  - Effective interval: (P+1)*(PRESCALE+1) CE cycles.
- Undefined: no prescaler logic; every CE cycle counts, and the PRESCALE parameter is ignored.

Decomposition:
- Package nor10_timer_pkg:
  - state enum (IDLE, RUN);
  - CNT_W=10 constant;
  - localparam helper for the prescaler width.
- One sub-module, nor10_zero_det: WIDTH-input NOR reduction producing ZERO.
  - Instantiated for the zero test used by both the FSM and the ZERO port, so both use an identical definition.

Test Plan:
- Reset: drive RSTN=0 mid-RUN with CNT=5 -> next edge CNT=0, BUSY=0, TC=0, ZERO=1.
- One-shot: LOAD LDVAL=3, START, CE=1 -> CNT 3,2,1,0; TC high exactly once, 4 cycles after BUSY rises; then BUSY=0, CNT=0.
- Auto-reload: AUTO_RELOAD=1, P=2, CE=1 for 12 cycles -> TC every 3 cycles (4 pulses); a LOAD of 5 mid-run changes the interval to 6 after the next TC.
- CE gating and STOP: P=4, CE toggling 1010... -> TC after 5 CE-high cycles. A separate STOP+START in the same cycle with CNT=2 -> IDLE, CNT=2, no TC.
- Boundary P=0 and restart: P=0 one-shot -> TC one cycle after BUSY rises. START with CNT==0 and CE=1 -> reload, no TC. P=1023 -> ZERO=0 until CNT reaches 0.
- TIMER_PRESCALE_EN defined, PRESCALE=3, P=1, CE=1 -> TC after 8 cycles. START mid-prescale -> prescaler clears and the full 8-cycle interval is restored.

Source files
------------

// File: rtl/nor10_timer_pkg.sv
// Shared types and constants for the NOR10 interval timer.
// Optional prescaler is selected with the TIMER_PRESCALE_EN macro.
package nor10_timer_pkg;

  localparam int CNT_W = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Prescaler counter width; never below one bit so PRESCALE=0 still elaborates.
  function automatic int psc_width(input int prescale);
    return (prescale < 1) ? 1 : $clog2(prescale + 1);
  endfunction

endpackage

// File: rtl/nor10_zero_det.sv
// WIDTH-input NOR reduction; same function as the schematic NOR10 macro.
module nor10_zero_det #(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] a,
  output logic             zero
);

  logic [WIDTH:0] any_chain;

  assign any_chain[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_or
      assign any_chain[gi+1] = any_chain[gi] | a[gi];
    end
  endgenerate

  assign zero = ~any_chain[WIDTH];

endmodule

// File: rtl/nor10_interval_timer.sv
// Programmable down-counting interval timer with NOR10-compatible count vector
// and registered TC pulse. Define TIMER_PRESCALE_EN to add the CE prescaler.
module nor10_interval_timer
  import nor10_timer_pkg::*;
#(
  parameter int WIDTH       = CNT_W,
  parameter int AUTO_RELOAD = 0,
  parameter int PRESCALE    = 3
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LDVAL,
  input  logic             START,
  input  logic             STOP,
  input  logic             CE,
  output logic [WIDTH-1:0] CNT,
  output logic             ZERO,
  output logic             TC,
  output logic             BUSY
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             cnt_zero;
  logic             count_tick;

  // One detector feeds both the FSM and the ZERO port.
  nor10_zero_det #(
    .WIDTH(WIDTH)
  ) u_zero_det (
    .a    (cnt_q),
    .zero (cnt_zero)
  );

`ifdef TIMER_PRESCALE_EN
  localparam int PSC_W = psc_width(PRESCALE);

  logic [PSC_W-1:0] psc_q, psc_d;
  logic             psc_wrap;

  assign psc_wrap   = (psc_q == PSC_W'(PRESCALE));
  assign count_tick = CE & psc_wrap;

  always_comb begin
    psc_d = psc_q;
    if (START || STOP) begin
      psc_d = '0;
    end else if (state_q == RUN && CE) begin
      psc_d = psc_wrap ? '0 : psc_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      psc_q <= '0;
    end else begin
      psc_q <= psc_d;
    end
  end
`else
  // PRESCALE has no effect in this build; the constant term folds away.
  assign count_tick = CE | (PRESCALE < 0);
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tc_d     = 1'b0;
    period_d = LOAD ? LDVAL : period_q;

    case (state_q)
      IDLE: begin
        if (START && !STOP) begin
          cnt_d   = period_q;
          state_d = RUN;
        end
      end
      RUN: begin
        if (STOP) begin
          state_d = IDLE;
        end else if (START) begin
          cnt_d = period_q;
        end else if (count_tick) begin
          if (!cnt_zero) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            // Expiry is intercepted at zero, so the decrement never wraps.
            tc_d = 1'b1;
            if (AUTO_RELOAD != 0) begin
              cnt_d = period_q;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q  <= IDLE;
      period_q <= '0;
      cnt_q    <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      tc_q     <= tc_d;
    end
  end

  assign CNT  = cnt_q;
  assign ZERO = cnt_zero;
  assign TC   = tc_q;
  assign BUSY = (state_q == RUN);

endmodule

// File: tb/tb_nor10_interval_timer.sv
// Scoreboard bench: stimulus queues expected TC cycles, monitors pop on each TC.
module tb_nor10_interval_timer;

  logic       clk = 1'b0;
  logic       rstn;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  int         q_os[$];
  int         q_ar[$];
  int         q_ps[$];

  logic       os_load, os_start, os_stop, os_ce;
  logic [9:0] os_ldval, os_cnt;
  logic       os_zero, os_tc, os_busy;
  logic       ar_load, ar_start, ar_stop, ar_ce;
  logic [9:0] ar_ldval, ar_cnt;
  logic       ar_zero, ar_tc, ar_busy;
  logic       ps_load, ps_start, ps_stop, ps_ce;
  logic [9:0] ps_ldval, ps_cnt;
  logic       ps_zero, ps_tc, ps_busy;

`ifdef TIMER_PRESCALE_EN
  localparam int PS_LEN = 8;
`else
  localparam int PS_LEN = 2;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nor10_interval_timer #(.WIDTH(10), .AUTO_RELOAD(0), .PRESCALE(0)) u_os (
    .CLK(clk), .RSTN(rstn), .LOAD(os_load), .LDVAL(os_ldval), .START(os_start),
    .STOP(os_stop), .CE(os_ce), .CNT(os_cnt), .ZERO(os_zero), .TC(os_tc), .BUSY(os_busy));

  nor10_interval_timer #(.WIDTH(10), .AUTO_RELOAD(1), .PRESCALE(0)) u_ar (
    .CLK(clk), .RSTN(rstn), .LOAD(ar_load), .LDVAL(ar_ldval), .START(ar_start),
    .STOP(ar_stop), .CE(ar_ce), .CNT(ar_cnt), .ZERO(ar_zero), .TC(ar_tc), .BUSY(ar_busy));

  nor10_interval_timer #(.WIDTH(10), .AUTO_RELOAD(0), .PRESCALE(3)) u_ps (
    .CLK(clk), .RSTN(rstn), .LOAD(ps_load), .LDVAL(ps_ldval), .START(ps_start),
    .STOP(ps_stop), .CE(ps_ce), .CNT(ps_cnt), .ZERO(ps_zero), .TC(ps_tc), .BUSY(ps_busy));

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic nx(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitors: every TC pulse must match the oldest expected cycle.
  always @(negedge clk) begin
    if (os_tc) begin
      if (q_os.size() == 0) check("os_tc_unexpected", cyc, -1);
      else check("os_tc_cycle", cyc, q_os.pop_front());
    end
    if (ar_tc) begin
      if (q_ar.size() == 0) check("ar_tc_unexpected", cyc, -1);
      else check("ar_tc_cycle", cyc, q_ar.pop_front());
    end
    if (ps_tc) begin
      if (q_ps.size() == 0) check("ps_tc_unexpected", cyc, -1);
      else check("ps_tc_cycle", cyc, q_ps.pop_front());
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s;
    int bad;
    rstn = 1'b0;
    {os_load, os_start, os_stop, os_ce} = '0; os_ldval = '0;
    {ar_load, ar_start, ar_stop, ar_ce} = '0; ar_ldval = '0;
    {ps_load, ps_start, ps_stop, ps_ce} = '0; ps_ldval = '0;
    nx(3);
    check("rst_cnt", int'(os_cnt), 0);
    check("rst_busy", int'(os_busy), 0);
    check("rst_tc", int'(os_tc), 0);
    check("rst_zero", int'(os_zero), 1);
    rstn = 1'b1;

    // One-shot, P=3
    os_load = 1; os_ldval = 3; nx(1);
    os_load = 0; os_start = 1; os_ce = 1; s = cyc + 1; q_os.push_back(s + 4); nx(1);
    os_start = 0;
    check("os3_busy_rise", int'(os_busy), 1);
    check("os3_cnt_start", int'(os_cnt), 3);
    for (int i = 1; i <= 3; i++) begin
      nx(1);
      check("os3_cnt_dec", int'(os_cnt), 3 - i);
    end
    nx(1);
    check("os3_busy_end", int'(os_busy), 0);
    check("os3_cnt_end", int'(os_cnt), 0);
    os_ce = 0; nx(3);

    // Reset mid-run with CNT=5; period register is cleared too
    os_load = 1; os_ldval = 5; nx(1);
    os_load = 0; os_start = 1; nx(1);
    os_start = 0;
    check("mid_cnt5", int'(os_cnt), 5);
    rstn = 0; nx(1);
    check("mid_rst_cnt", int'(os_cnt), 0);
    check("mid_rst_busy", int'(os_busy), 0);
    check("mid_rst_tc", int'(os_tc), 0);
    check("mid_rst_zero", int'(os_zero), 1);
    rstn = 1;
    os_start = 1; nx(1);
    os_start = 0;
    check("rst_period_cnt", int'(os_cnt), 0);
    check("rst_period_busy", int'(os_busy), 1);
    os_stop = 1; nx(1);
    os_stop = 0;
    check("stop_busy", int'(os_busy), 0);

    // CE gating 1010..., P=4 -> TC after 5 CE-high cycles
    os_load = 1; os_ldval = 4; nx(1);
    os_load = 0; os_start = 1; s = cyc + 1; q_os.push_back(s + 9); nx(1);
    os_start = 0;
    for (int k = 0; k < 10; k++) begin
      os_ce = (k % 2 == 0);
      nx(1);
    end
    check("ce_gate_busy", int'(os_busy), 0);
    check("ce_gate_cnt", int'(os_cnt), 0);

    // STOP beats START with CNT=2
    os_load = 1; os_ldval = 4; nx(1);
    os_load = 0; os_start = 1; nx(1);
    os_start = 0; os_ce = 1; nx(2);
    os_ce = 0;
    check("ss_cnt_pre", int'(os_cnt), 2);
    os_stop = 1; os_start = 1; nx(1);
    os_stop = 0; os_start = 0;
    check("ss_busy", int'(os_busy), 0);
    check("ss_cnt", int'(os_cnt), 2);
    check("ss_zero", int'(os_zero), 0);
    nx(3);
    check("ss_cnt_hold", int'(os_cnt), 2);

    // P=0 one-shot -> TC one cycle after BUSY rises
    os_load = 1; os_ldval = 0; nx(1);
    os_load = 0; os_start = 1; os_ce = 1; s = cyc + 1; q_os.push_back(s + 1); nx(1);
    os_start = 0;
    check("p0_busy", int'(os_busy), 1);
    check("p0_zero", int'(os_zero), 1);
    nx(1);
    check("p0_busy_end", int'(os_busy), 0);
    os_ce = 0; nx(2);

    // START while CNT==0 with CE=1 -> reload, no TC
    os_load = 1; os_ldval = 2; nx(1);
    os_load = 0; os_start = 1; os_ce = 1; s = cyc + 1; q_os.push_back(s + 6); nx(1);
    os_start = 0; nx(2);
    check("rz_cnt0", int'(os_cnt), 0);
    os_start = 1; nx(1);
    os_start = 0;
    check("rz_cnt_reload", int'(os_cnt), 2);
    check("rz_busy", int'(os_busy), 1);
    nx(3);
    check("rz_busy_end", int'(os_busy), 0);
    os_ce = 0; nx(2);

    // P=1023: ZERO low until CNT reaches 0
    os_load = 1; os_ldval = 10'd1023; nx(1);
    os_load = 0; os_start = 1; os_ce = 1; s = cyc + 1; q_os.push_back(s + 1024); nx(1);
    os_start = 0;
    bad = 0;
    for (int i = 0; i < 1023; i++) begin
      if (os_zero) bad++;
      nx(1);
    end
    check("p1023_zero_early", bad, 0);
    check("p1023_cnt_end", int'(os_cnt), 0);
    check("p1023_zero_end", int'(os_zero), 1);
    nx(1);
    os_ce = 0; nx(2);

    // Auto-reload P=2, then LOAD 5 mid-run
    ar_load = 1; ar_ldval = 2; nx(1);
    ar_load = 0; ar_start = 1; ar_ce = 1; s = cyc + 1;
    q_ar.push_back(s + 3);  q_ar.push_back(s + 6);  q_ar.push_back(s + 9);
    q_ar.push_back(s + 12); q_ar.push_back(s + 15); q_ar.push_back(s + 21);
    q_ar.push_back(s + 27);
    nx(1);
    ar_start = 0; nx(12);
    check("ar_busy_run", int'(ar_busy), 1);
    check("ar_cnt_reload", int'(ar_cnt), 2);
    nx(1);
    ar_load = 1; ar_ldval = 5; nx(1);
    ar_load = 0; nx(13);
    ar_stop = 1; ar_ce = 0; nx(1);
    ar_stop = 0;
    check("ar_stop_busy", int'(ar_busy), 0);
    check("ar_stop_cnt", int'(ar_cnt), 5);

    // Auto-reload P=0 -> TC continuous until STOP
    ar_load = 1; ar_ldval = 0; nx(1);
    ar_load = 0; ar_start = 1; ar_ce = 1; s = cyc + 1;
    q_ar.push_back(s + 1); q_ar.push_back(s + 2); q_ar.push_back(s + 3);
    nx(1);
    ar_start = 0; nx(3);
    ar_stop = 1; nx(1);
    ar_stop = 0; ar_ce = 0;
    check("ar0_busy", int'(ar_busy), 0);
    nx(2);

    // Prescaled instance, P=1, then restart mid-interval
    ps_load = 1; ps_ldval = 1; nx(1);
    ps_load = 0; ps_start = 1; ps_ce = 1; s = cyc + 1; q_ps.push_back(s + PS_LEN); nx(1);
    ps_start = 0; nx(PS_LEN - 1);
    check("ps_busy_pre", int'(ps_busy), 1);
    nx(1);
    check("ps_busy_end", int'(ps_busy), 0);
    ps_start = 1; s = cyc + 1; q_ps.push_back(s + 2 + PS_LEN); nx(1);
    ps_start = 0; nx(1);
    ps_start = 1; nx(1);
    ps_start = 0;
    check("ps_restart_cnt", int'(ps_cnt), 1);
    nx(PS_LEN - 1);
    check("ps_restart_busy", int'(ps_busy), 1);
    nx(1);
    check("ps_restart_end", int'(ps_busy), 0);
    ps_ce = 0;

    nx(3);
    check("os_q_empty", q_os.size(), 0);
    check("ar_q_empty", q_ar.size(), 0);
    check("ps_q_empty", q_ps.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
